// File: rtl/id_ex_fwd_reg_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_fwd_reg_pkg
//
// Shared definitions for the ID/EX forwarding register:
//   - opcode constants, including CTRL_LW, which identifies a load in EX
//   - instruction field extractors (opcode, rs, rt)
//   - ex_state_t, the bundle of state the ID/EX register holds
//   - load_use_hazard(), the conservative load-use check
//
// Widths are fixed: 32-bit data and instructions, 5-bit register addresses.
// ---------------------------------------------------------------------------
package id_ex_fwd_reg_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // Opcode field values (Instr[31:26]).
    localparam logic [5:0] CTRL_SPECIAL = 6'b000000;
    localparam logic [5:0] CTRL_LW      = 6'b100011;
    localparam logic [5:0] CTRL_SW      = 6'b101011;
    localparam logic [5:0] CTRL_BEQ     = 6'b000100;

    // $0 is hard-wired to zero, so it is never forwarded.
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    // Everything captured by the ID/EX register. All-zero is a bubble,
    // because an all-zero instruction word is a nop.
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] reg_a;
        logic [DATA_W-1:0] reg_b;
    } ex_state_t;

    function automatic logic [5:0] instr_opcode(input logic [DATA_W-1:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [ADDR_W-1:0] instr_rs(input logic [DATA_W-1:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [ADDR_W-1:0] instr_rt(input logic [DATA_W-1:0] instr);
        return instr[20:16];
    endfunction

    // A load in EX whose destination (rt) is read by the instruction in ID.
    // Both ID source fields are compared whatever the ID opcode is; a false
    // stall costs one cycle, a missed one returns stale data.
    function automatic logic load_use_hazard(input logic [DATA_W-1:0] ex_instr,
                                             input logic [DATA_W-1:0] id_instr);
        logic [ADDR_W-1:0] ld_dst;
        ld_dst = instr_rt(ex_instr);
        return (instr_opcode(ex_instr) == CTRL_LW) &&
               (ld_dst != REG_ZERO) &&
               ((ld_dst == instr_rs(id_instr)) || (ld_dst == instr_rt(id_instr)));
    endfunction

endpackage

// File: rtl/id_ex_fwd_reg_fwd_mux.sv
// ---------------------------------------------------------------------------
// id_ex_fwd_reg_fwd_mux
//
// Priority forwarding select for one operand.
//   src      : source register field of the consuming instruction
//   dflt     : value used when no forward applies (GRF read / held register)
//   hi_en    : enables the high-priority pair (EX/MEM forward)
//   hi_addr  : high-priority forward address
//   hi_value : high-priority forward value
//   lo_addr  : low-priority forward address (MEM/WB forward)
//   lo_value : low-priority forward value
//   result   : selected operand
//
// A source field of $0 always takes dflt, even when a forward pair carries
// address 0 with a nonzero value.
// ---------------------------------------------------------------------------
module id_ex_fwd_reg_fwd_mux
    import id_ex_fwd_reg_pkg::*;
(
    input  logic [ADDR_W-1:0] src,
    input  logic [DATA_W-1:0] dflt,
    input  logic              hi_en,
    input  logic [ADDR_W-1:0] hi_addr,
    input  logic [DATA_W-1:0] hi_value,
    input  logic [ADDR_W-1:0] lo_addr,
    input  logic [DATA_W-1:0] lo_value,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = dflt;
        if (src != REG_ZERO) begin
            // The younger producer (EX/MEM) holds the newer value, so it wins.
            if (hi_en && (src == hi_addr)) begin
                result = hi_value;
            end else if (src == lo_addr) begin
                result = lo_value;
            end
        end
    end

endmodule

// File: rtl/id_ex_fwd_reg.sv
// ---------------------------------------------------------------------------
// id_ex_fwd_reg
//
// ID/EX pipeline register at the consumer end of the forwarding path.
// It captures ID-stage state, applies the MEM/WB forward at capture time
// (covering a GRF write and read on the same edge), applies EX/MEM and
// MEM/WB forwards again on the EX side, and requests a one-cycle stall on
// a load-use hazard, loading a bubble into itself during that cycle.
//
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   PC, PC4, Instr        : ID-stage values
//   ReadDataA, ReadDataB  : GRF reads for Instr[25:21] / Instr[20:16]
//   MemFWAddr/MemFWValue  : EX/MEM forward pair (address 0 = no forward)
//   WbFWAddr/WbFWValue    : MEM/WB forward pair (address 0 = no forward)
//   Stall                 : combinational hold request to PC and IF/ID
//   Ex_PC, Ex_PC4, Ex_Instr : registered ID-stage values
//   Ex_OperandA/B         : held operands after EX-side bypass
//   StallCount            : stall cycle counter, present only when the
//                           STALL_CNT_EN macro is defined
// ---------------------------------------------------------------------------
module id_ex_fwd_reg
    import id_ex_fwd_reg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] PC,
    input  logic [DATA_W-1:0] PC4,
    input  logic [DATA_W-1:0] Instr,
    input  logic [DATA_W-1:0] ReadDataA,
    input  logic [DATA_W-1:0] ReadDataB,
    input  logic [ADDR_W-1:0] MemFWAddr,
    input  logic [DATA_W-1:0] MemFWValue,
    input  logic [ADDR_W-1:0] WbFWAddr,
    input  logic [DATA_W-1:0] WbFWValue,
    output logic              Stall,
    output logic [DATA_W-1:0] Ex_PC,
    output logic [DATA_W-1:0] Ex_PC4,
    output logic [DATA_W-1:0] Ex_Instr,
    output logic [DATA_W-1:0] Ex_OperandA,
    output logic [DATA_W-1:0] Ex_OperandB
`ifdef STALL_CNT_EN
    ,
    output logic [DATA_W-1:0] StallCount
`endif
);

    ex_state_t         ex_q;
    ex_state_t         ex_d;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic              stall;

    // -----------------------------------------------------------------------
    // Load-use detection. The load's data is not available until it reaches
    // WB, so the consumer waits one cycle in ID while a bubble enters EX.
    // -----------------------------------------------------------------------
    assign stall = load_use_hazard(ex_q.instr, Instr);
    assign Stall = stall;

    // -----------------------------------------------------------------------
    // Capture-side bypass. Only the MEM/WB pair matters here: that value is
    // being written to the GRF on this same edge, so the GRF read is stale.
    // The EX/MEM pair is disabled; it is picked up on the EX side instead.
    // -----------------------------------------------------------------------
    id_ex_fwd_reg_fwd_mux fwd_mux_cap_a (
        .src      (instr_rs(Instr)),
        .dflt     (ReadDataA),
        .hi_en    (1'b0),
        .hi_addr  (MemFWAddr),
        .hi_value (MemFWValue),
        .lo_addr  (WbFWAddr),
        .lo_value (WbFWValue),
        .result   (cap_a)
    );

    id_ex_fwd_reg_fwd_mux fwd_mux_cap_b (
        .src      (instr_rt(Instr)),
        .dflt     (ReadDataB),
        .hi_en    (1'b0),
        .hi_addr  (MemFWAddr),
        .hi_value (MemFWValue),
        .lo_addr  (WbFWAddr),
        .lo_value (WbFWValue),
        .result   (cap_b)
    );

    // -----------------------------------------------------------------------
    // Next-state: the ID bundle, or a bubble when stalling. A bubble wins
    // over any capture-side forward.
    // -----------------------------------------------------------------------
    always_comb begin
        ex_d = '0;
        if (!stall) begin
            ex_d.pc    = PC;
            ex_d.pc4   = PC4;
            ex_d.instr = Instr;
            ex_d.reg_a = cap_a;
            ex_d.reg_b = cap_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // -----------------------------------------------------------------------
    // EX-side bypass on the held operands, using the fields of the
    // instruction now in EX. Mem has priority over Wb.
    // -----------------------------------------------------------------------
    id_ex_fwd_reg_fwd_mux fwd_mux_ex_a (
        .src      (instr_rs(ex_q.instr)),
        .dflt     (ex_q.reg_a),
        .hi_en    (1'b1),
        .hi_addr  (MemFWAddr),
        .hi_value (MemFWValue),
        .lo_addr  (WbFWAddr),
        .lo_value (WbFWValue),
        .result   (Ex_OperandA)
    );

    id_ex_fwd_reg_fwd_mux fwd_mux_ex_b (
        .src      (instr_rt(ex_q.instr)),
        .dflt     (ex_q.reg_b),
        .hi_en    (1'b1),
        .hi_addr  (MemFWAddr),
        .hi_value (MemFWValue),
        .lo_addr  (WbFWAddr),
        .lo_value (WbFWValue),
        .result   (Ex_OperandB)
    );

    assign Ex_PC    = ex_q.pc;
    assign Ex_PC4   = ex_q.pc4;
    assign Ex_Instr = ex_q.instr;

`ifdef STALL_CNT_EN
    // Counts edges on which a bubble was inserted; wraps naturally.
    logic [DATA_W-1:0] stall_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (stall) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign StallCount = stall_count_q;
`endif

endmodule
